isa_test_monitor: RTL and testbench

//  Synthesizable end-of-test detector for NF5 ISA self-checking programs. Watches the IF/ID PC

---
 rtl/test_mon_pkg.sv | 18 +
 rtl/test_mon_window_cmp.sv | 17 +
 rtl/isa_test_monitor.sv | 155 +++++++++++++++
 tb/tb_isa_test_monitor.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/test_mon_pkg.sv
// Shared types for the ISA end-of-test monitor: FSM states and verdict encodings.
package test_mon_pkg;

  typedef enum logic [1:0] {
    TM_RUN,
    TM_CONF_P,
    TM_CONF_F,
    TM_DONE
  } tm_state_e;

  typedef enum logic [1:0] {
    TM_RES_NONE,
    TM_RES_PASS,
    TM_RES_FAIL,
    TM_RES_TIMEOUT
  } tm_res_e;

endpackage

// File: rtl/test_mon_window_cmp.sv
// Inclusive PC window compare: hit when valid and BASE <= pc <= BASE+SPAN (unsigned, XLEN-bit).
module test_mon_window_cmp #(
  parameter int               XLEN = 32,
  parameter logic [XLEN-1:0]  BASE = 32'h0000_0100,
  parameter int               SPAN = 8
) (
  input  logic            valid,
  input  logic [XLEN-1:0] pc,
  output logic            hit
);

  // Upper bound wraps at XLEN bits, matching the unsigned window definition.
  localparam logic [XLEN-1:0] TOP = BASE + XLEN'(SPAN);

  assign hit = valid && (pc >= BASE) && (pc <= TOP);

endmodule

// File: rtl/isa_test_monitor.sv
// End-of-test detector: confirms a parked pass/fail PC loop, runs a cycle watchdog, latches a verdict.
// Optional tohost store snooping is enabled with `define TEST_MON_TOHOST_EN.
module isa_test_monitor
  import test_mon_pkg::*;
#(
  parameter int               XLEN        = 32,
  parameter int               CNT_W       = 32,
  parameter logic [XLEN-1:0]  PASS_PC     = 32'h0000_0224,
  parameter logic [XLEN-1:0]  FAIL_PC     = 32'h0000_0210,
  parameter int               WINDOW      = 8,
  parameter int               HOLD_CYCLES = 2,
`ifdef TEST_MON_TOHOST_EN
  parameter logic [XLEN-1:0]  TOHOST_ADDR = 32'h0000_1000,
`endif
  parameter int               TIMEOUT     = 650
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_valid,
  input  logic [XLEN-1:0]  pc,
`ifdef TEST_MON_TOHOST_EN
  input  logic             st_valid,
  input  logic [XLEN-1:0]  st_addr,
  input  logic [XLEN-1:0]  st_wdata,
  output logic [XLEN-2:0]  test_num,
`endif
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] done_cycle,
  output logic [XLEN-1:0]  done_pc
);

  localparam int              HC_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0] HOLD = HC_W'(HOLD_CYCLES);
  localparam logic [HC_W-1:0] ONE  = HC_W'(1);

  tm_state_e       state, nxt_state;
  logic [HC_W-1:0] hit_cnt, nxt_cnt;
  logic            hit_p_raw, hit_p, hit_f;
  logic            conf_p, conf_f, wd_fire;
  tm_res_e         res, pc_res;

  test_mon_window_cmp #(.XLEN(XLEN), .BASE(PASS_PC), .SPAN(WINDOW)) u_win_pass (
    .valid (pc_valid),
    .pc    (pc),
    .hit   (hit_p_raw)
  );

  test_mon_window_cmp #(.XLEN(XLEN), .BASE(FAIL_PC), .SPAN(WINDOW)) u_win_fail (
    .valid (pc_valid),
    .pc    (pc),
    .hit   (hit_f)
  );

  // Overlapping windows resolve to fail, so a pass hit never coexists with a fail hit.
  assign hit_p = hit_p_raw & ~hit_f;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = hit_cnt;
    case (state)
      TM_RUN: begin
        if (hit_f) begin
          nxt_state = TM_CONF_F;
          nxt_cnt   = ONE;
        end else if (hit_p) begin
          nxt_state = TM_CONF_P;
          nxt_cnt   = ONE;
        end
      end
      TM_CONF_P, TM_CONF_F: begin
        if (pc_valid) begin
          if ((state == TM_CONF_P && hit_p) || (state == TM_CONF_F && hit_f)) begin
            nxt_cnt = (hit_cnt == HOLD) ? HOLD : hit_cnt + ONE;
          end else if (hit_f) begin
            nxt_state = TM_CONF_F;
            nxt_cnt   = ONE;
          end else if (hit_p) begin
            nxt_state = TM_CONF_P;
            nxt_cnt   = ONE;
          end else begin
            nxt_state = TM_RUN;
            nxt_cnt   = '0;
          end
        end
      end
      default: ;
    endcase
  end

  // A confirm needs the incoming hit itself to bring the count to HOLD; bubbles never confirm.
  assign conf_p  = hit_p && (nxt_state == TM_CONF_P) && (nxt_cnt == HOLD);
  assign conf_f  = hit_f && (nxt_state == TM_CONF_F) && (nxt_cnt == HOLD);
  assign wd_fire = (TIMEOUT != 0) && (cycle_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    pc_res = TM_RES_NONE;
    if (state != TM_DONE) begin
      if (conf_f)       pc_res = TM_RES_FAIL;
      else if (conf_p)  pc_res = TM_RES_PASS;
      else if (wd_fire) pc_res = TM_RES_TIMEOUT;
    end
  end

`ifdef TEST_MON_TOHOST_EN
  logic th_fire;
  assign th_fire = (state != TM_DONE) && st_valid && (st_addr == TOHOST_ADDR) && st_wdata[0];

  // A tohost store outranks both the PC confirm and the watchdog.
  always_comb begin
    res = pc_res;
    if (th_fire) res = (st_wdata == XLEN'(1)) ? TM_RES_PASS : TM_RES_FAIL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        test_num <= '0;
    else if (th_fire && st_wdata != XLEN'(1))          test_num <= st_wdata[XLEN-1:1];
  end
`else
  assign res = pc_res;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= TM_RUN;
      hit_cnt    <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      cycle_cnt  <= '0;
      done_cycle <= '0;
      done_pc    <= '0;
    end else if (state != TM_DONE) begin
      if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
      if (res != TM_RES_NONE) begin
        state      <= TM_DONE;
        hit_cnt    <= '0;
        done       <= 1'b1;
        pass       <= (res == TM_RES_PASS);
        fail       <= (res == TM_RES_FAIL);
        timeout    <= (res == TM_RES_TIMEOUT);
        done_cycle <= cycle_cnt;
        done_pc    <= (res == TM_RES_TIMEOUT) ? '0 : pc;
      end else begin
        state   <= nxt_state;
        hit_cnt <= nxt_cnt;
      end
    end
  end

endmodule

// File: tb/tb_isa_test_monitor.sv
// Table-driven bench for isa_test_monitor with a per-cycle scoreboard queue.
module tb_isa_test_monitor;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_valid = 1'b0;
  logic [31:0] pc = '0;
  logic        done, pass, fail, timeout;
  logic [31:0] cycle_cnt, done_cycle, done_pc;
`ifdef TEST_MON_TOHOST_EN
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_wdata = '0;
  logic [30:0] test_num;
`endif

  always #5 clk = ~clk;

  isa_test_monitor #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_valid   (pc_valid),
    .pc         (pc),
`ifdef TEST_MON_TOHOST_EN
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_wdata   (st_wdata),
    .test_num   (test_num),
`endif
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .timeout    (timeout),
    .cycle_cnt  (cycle_cnt),
    .done_cycle (done_cycle),
    .done_pc    (done_pc)
  );

  // fl = {done, pass, fail, timeout}
  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        st;
    logic [31:0] sd;
    logic [3:0]  fl;
    logic [31:0] dpc;
    int          dcyc;
    logic [30:0] tn;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add_st(input logic v, input logic [31:0] p, input logic st, input logic [31:0] sd,
                        input logic [3:0] fl, input logic [31:0] dpc, input int dcyc,
                        input logic [30:0] tn);
    vec_t e;
    e.v = v; e.pc = p; e.st = st; e.sd = sd; e.fl = fl; e.dpc = dpc; e.dcyc = dcyc; e.tn = tn;
    tbl.push_back(e);
  endtask

  task automatic add(input logic v, input logic [31:0] p, input logic [3:0] fl,
                     input logic [31:0] dpc, input int dcyc);
    add_st(v, p, 1'b0, 32'h0, fl, dpc, dcyc, 31'h0);
  endtask

  task automatic add_miss(input int n, input logic [31:0] p);
    for (int i = 0; i < n; i++) add(1'b1, p, 4'b0000, 32'h0, 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0; pc_valid = 1'b0; pc = '0;
`ifdef TEST_MON_TOHOST_EN
    st_valid = 1'b0; st_addr = '0; st_wdata = '0;
`endif
    @(posedge clk); #1;
    chk({tag, ".rst_flags"}, 32'({done, pass, fail, timeout}), 32'h0);
    chk({tag, ".rst_cycle_cnt"}, cycle_cnt, 32'h0);
    chk({tag, ".rst_done_cycle"}, done_cycle, 32'h0);
    chk({tag, ".rst_done_pc"}, done_pc, 32'h0);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic run(input string tag);
    vec_t e, r;
    do_reset(tag);
    foreach (tbl[i]) begin
      e = tbl[i];
      pc_valid = e.v;
      pc       = e.pc;
`ifdef TEST_MON_TOHOST_EN
      st_valid = e.st;
      st_addr  = 32'h0000_1000;
      st_wdata = e.sd;
`endif
      sb.push_back(e);
      @(posedge clk); #1;
      cyc++;
      r = sb.pop_front();
      chk($sformatf("%s[%0d].flags", tag, i), 32'({done, pass, fail, timeout}), 32'(r.fl));
      chk($sformatf("%s[%0d].cycle_cnt", tag, i), cycle_cnt,
          r.fl[3] ? 32'(r.dcyc + 1) : 32'(cyc));
      chk($sformatf("%s[%0d].done_cycle", tag, i), done_cycle, r.fl[3] ? 32'(r.dcyc) : 32'h0);
      chk($sformatf("%s[%0d].done_pc", tag, i), done_pc, r.fl[3] ? r.dpc : 32'h0);
`ifdef TEST_MON_TOHOST_EN
      chk($sformatf("%s[%0d].test_num", tag, i), 32'(test_num), 32'(r.tn));
`endif
    end
    tbl.delete();
  endtask

  initial begin
    // PC sweep below the windows, then two pass hits confirm; later inputs are ignored.
    for (int i = 0; i < 16; i++) add(1'b1, 32'h100 + 32'(i * 16), 4'b0000, 32'h0, 0);
    add(1'b1, 32'h224, 4'b0000, 32'h0, 0);
    add(1'b1, 32'h224, 4'b1100, 32'h224, 17);
    add(1'b1, 32'h210, 4'b1100, 32'h224, 17);
    add(1'b0, 32'h224, 4'b1100, 32'h224, 17);
    run("pass_sweep");

    // A valid miss between fail hits restarts the count.
    add(1'b1, 32'h210, 4'b0000, 32'h0, 0);
    add(1'b1, 32'h300, 4'b0000, 32'h0, 0);
    add(1'b1, 32'h210, 4'b0000, 32'h0, 0);
    add(1'b1, 32'h210, 4'b1010, 32'h210, 3);
    run("fail_miss");

    // Bubbles hold the confirm count; 0x228 is inside the pass window.
    add(1'b1, 32'h224, 4'b0000, 32'h0, 0);
    add(1'b0, 32'h300, 4'b0000, 32'h0, 0);
    add(1'b0, 32'h300, 4'b0000, 32'h0, 0);
    add(1'b0, 32'h300, 4'b0000, 32'h0, 0);
    add(1'b1, 32'h228, 4'b1100, 32'h228, 4);
    run("bubble");

    // Pass window edges: 0x22C in, 0x22D and 0x223 out.
    add(1'b1, 32'h22C, 4'b0000, 32'h0, 0);
    add(1'b1, 32'h22D, 4'b0000, 32'h0, 0);
    add(1'b1, 32'h223, 4'b0000, 32'h0, 0);
    add(1'b1, 32'h22C, 4'b0000, 32'h0, 0);
    add(1'b1, 32'h224, 4'b1100, 32'h224, 4);
    run("pass_edges");

    // Window switching and fail window edges.
    add(1'b1, 32'h218, 4'b0000, 32'h0, 0);
    add(1'b1, 32'h224, 4'b0000, 32'h0, 0);
    add(1'b1, 32'h210, 4'b0000, 32'h0, 0);
    add(1'b1, 32'h20F, 4'b0000, 32'h0, 0);
    add(1'b1, 32'h219, 4'b0000, 32'h0, 0);
    add(1'b1, 32'h218, 4'b0000, 32'h0, 0);
    add(1'b1, 32'h210, 4'b1010, 32'h210, 6);
    run("switch");

    // Watchdog fires on the cycle_cnt==TO-1 edge and the counter then freezes.
    add_miss(TO - 1, 32'h400);
    add(1'b1, 32'h400, 4'b1001, 32'h0, TO - 1);
    add(1'b1, 32'h224, 4'b1001, 32'h0, TO - 1);
    add(1'b1, 32'h224, 4'b1001, 32'h0, TO - 1);
    run("timeout");

    // A confirm on the watchdog edge wins.
    add_miss(TO - 2, 32'h400);
    add(1'b1, 32'h224, 4'b0000, 32'h0, 0);
    add(1'b1, 32'h224, 4'b1100, 32'h224, TO - 1);
    add(1'b1, 32'h400, 4'b1100, 32'h224, TO - 1);
    run("race");

    // Asynchronous reset while DONE clears the verdict without waiting for a clock edge.
    rst_n = 1'b0;
    #2;
    chk("async_rst.flags", 32'({done, pass, fail, timeout}), 32'h0);
    chk("async_rst.cycle_cnt", cycle_cnt, 32'h0);
    chk("async_rst.done_pc", done_pc, 32'h0);
    chk("async_rst.done_cycle", done_cycle, 32'h0);

`ifdef TEST_MON_TOHOST_EN
    add_st(1'b1, 32'h300, 1'b1, 32'h7, 4'b1010, 32'h300, 0, 31'd3);
    add_st(1'b1, 32'h224, 1'b1, 32'h1, 4'b1010, 32'h300, 0, 31'd3);
    run("tohost_fail");

    add(1'b1, 32'h210, 4'b0000, 32'h0, 0);
    add_st(1'b1, 32'h210, 1'b1, 32'h1, 4'b1100, 32'h210, 1, 31'd0);
    run("tohost_race");

    add_st(1'b1, 32'h300, 1'b1, 32'h2, 4'b0000, 32'h0, 0, 31'd0);
    add_st(1'b0, 32'h0, 1'b1, 32'h2, 4'b0000, 32'h0, 0, 31'd0);
    add(1'b1, 32'h224, 4'b0000, 32'h0, 0);
    add(1'b1, 32'h224, 4'b1100, 32'h224, 3);
    run("tohost_even");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
